// File: rtl/decode_result_arbiter.sv
// Merges per-decoder result streams into one stream ordered by major ID, with a 2-entry FIFO per source.
// Define DECODE_ARB_BYPASS_EN to let an idle arbiter load straight from the inputs (1-cycle latency).

module decode_result_fifo #(
  parameter int width     = 192,
  parameter int fifoDepth = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] data_i,
  output logic [width-1:0] head_o,
  output logic [1:0]       count_o
);
  logic [width-1:0] mem [2];
  logic             rdPtr, wrPtr;
  logic             pushOk;

  // A push into a full FIFO is dropped even when the same edge pops it.
  assign pushOk = push_i && (count_o != 2'(fifoDepth));
  assign head_o = mem[rdPtr];

  always_ff @(posedge clock_i) begin
    if (pushOk) mem[wrPtr] <= data_i;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rdPtr   <= 1'b0;
      wrPtr   <= 1'b0;
      count_o <= 2'd0;
    end else begin
      if (pushOk) wrPtr <= ~wrPtr;
      if (pop_i)  rdPtr <= ~rdPtr;
      count_o <= count_o + 2'(pushOk) - 2'(pop_i);
    end
  end
endmodule

module decode_result_arbiter #(
  parameter int numSources              = 4,
  parameter int payloadWidth            = 128,
  parameter int instructionCounterWidth = 64,
  parameter int fifoDepth               = 2
) (
  input  logic                                       clock_i,
  input  logic                                       reset_i,
  input  logic [numSources-1:0]                      enable_i,
  input  logic [numSources*payloadWidth-1:0]         payload_i,
  input  logic [numSources*instructionCounterWidth-1:0] majId_i,
  input  logic                                       stall_i,
  output logic [numSources-1:0]                      stall_o,
  output logic                                       enable_o,
  output logic [payloadWidth-1:0]                    payload_o,
  output logic [instructionCounterWidth-1:0]         majId_o,
  output logic [$clog2(numSources)-1:0]              source_o,
  output logic                                       error_o
);
  localparam int srcW   = $clog2(numSources);
  localparam int idW    = instructionCounterWidth;
  localparam int entryW = payloadWidth + idW;

  logic [numSources-1:0][entryW-1:0] entryIn, head;
  logic [numSources-1:0][1:0]        count;
  logic [numSources-1:0]             nonEmpty, push, pop;

  logic              outFree;
  logic              selValid;
  logic [srcW-1:0]   selIdx;
  logic [idW-1:0]    selMaj;

  logic              bypass;
  logic [srcW-1:0]   bypIdx;
  logic [idW-1:0]    bypMaj;

  assign outFree = !enable_o || !stall_i;

  genvar g;
  generate
    for (g = 0; g < numSources; g++) begin : gSrc
      assign entryIn[g]  = {majId_i[g*idW +: idW], payload_i[g*payloadWidth +: payloadWidth]};
      assign nonEmpty[g] = (count[g] != 2'd0);
      assign stall_o[g]  = (count[g] == 2'(fifoDepth));

      decode_result_fifo #(.width(entryW), .fifoDepth(fifoDepth)) uFifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (push[g]),
        .pop_i   (pop[g]),
        .data_i  (entryIn[g]),
        .head_o  (head[g]),
        .count_o (count[g])
      );
    end
  endgenerate

  // Oldest head wins; strict less-than keeps ties on the lowest index.
  always_comb begin
    selValid = 1'b0;
    selIdx   = '0;
    selMaj   = '0;
    for (int k = 0; k < numSources; k++) begin
      if (nonEmpty[k] && (!selValid || head[k][entryW-1 -: idW] < selMaj)) begin
        selValid = 1'b1;
        selIdx   = srcW'(k);
        selMaj   = head[k][entryW-1 -: idW];
      end
    end
  end

`ifdef DECODE_ARB_BYPASS_EN
  logic bypValid;
  always_comb begin
    bypValid = 1'b0;
    bypIdx   = '0;
    bypMaj   = '0;
    for (int k = 0; k < numSources; k++) begin
      if (enable_i[k] && (!bypValid || majId_i[k*idW +: idW] < bypMaj)) begin
        bypValid = 1'b1;
        bypIdx   = srcW'(k);
        bypMaj   = majId_i[k*idW +: idW];
      end
    end
  end
  assign bypass = outFree && (nonEmpty == '0) && bypValid;
`else
  assign bypass = 1'b0;
  assign bypIdx = '0;
  assign bypMaj = '0;
`endif

  // The bypassed source skips its FIFO; everyone else still pushes.
  assign push = bypass ? (enable_i & ~({{(numSources-1){1'b0}}, 1'b1} << bypIdx)) : enable_i;
  assign pop  = (outFree && selValid && !bypass) ? ({{(numSources-1){1'b0}}, 1'b1} << selIdx) : '0;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      enable_o  <= 1'b0;
      payload_o <= '0;
      majId_o   <= '0;
      source_o  <= '0;
      error_o   <= 1'b0;
    end else begin
      if (|(enable_i & stall_o)) error_o <= 1'b1;
      if (outFree) begin
        if (bypass) begin
          enable_o  <= 1'b1;
          payload_o <= payload_i[bypIdx*payloadWidth +: payloadWidth];
          majId_o   <= bypMaj;
          source_o  <= bypIdx;
        end else if (selValid) begin
          enable_o  <= 1'b1;
          payload_o <= head[selIdx][payloadWidth-1:0];
          majId_o   <= selMaj;
          source_o  <= selIdx;
        end else begin
          enable_o  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_decode_result_arbiter.sv
// Directed bench for decode_result_arbiter (default build, 2-cycle latency), 4 sources, 16-bit fields.

module tb_decode_result_arbiter;
  localparam int NS = 4;
  localparam int PW = 16;
  localparam int IW = 16;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic [NS-1:0]     enable_i;
  logic [NS*PW-1:0]  payload_i;
  logic [NS*IW-1:0]  majId_i;
  logic              stall_i;
  logic [NS-1:0]     stall_o;
  logic              enable_o;
  logic [PW-1:0]     payload_o;
  logic [IW-1:0]     majId_o;
  logic [1:0]        source_o;
  logic              error_o;

  int checks = 0;
  int errors = 0;

  decode_result_arbiter #(
    .numSources(NS), .payloadWidth(PW), .instructionCounterWidth(IW), .fifoDepth(2)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .payload_i(payload_i),
    .majId_i(majId_i), .stall_i(stall_i), .stall_o(stall_o), .enable_o(enable_o),
    .payload_o(payload_o), .majId_o(majId_o), .source_o(source_o), .error_o(error_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [3:0]  en;
    logic [15:0] m0, m1, m2, m3;
    logic        stall;
    logic        eEn;
    logic [15:0] eMaj;
    logic [1:0]  eSrc;
    logic [3:0]  eStallO;
    logic        eErr;
  } vec_t;

  vec_t tbl [19];

  // Payload tags the source in the top bits so a wrong-source load is visible.
  function automatic logic [15:0] mkPay(input int src, input logic [15:0] maj);
    return {2'(src), maj[13:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [15:0] m0, m1, m2, m3, input logic st);
    enable_i  = en;
    majId_i   = {m3, m2, m1, m0};
    payload_i = {mkPay(3, m3), mkPay(2, m2), mkPay(1, m1), mkPay(0, m0)};
    stall_i   = st;
  endtask

  task automatic stepCheck(input string nm, input logic eEn, input logic [15:0] eMaj,
                           input logic [1:0] eSrc, input logic [3:0] eStallO, input logic eErr);
    logic [63:0] act, exp;
    @(posedge clock_i);
    @(negedge clock_i);
    act = {enable_o, eEn ? majId_o : 16'h0, eEn ? source_o : 2'h0,
           eEn ? payload_o : 16'h0, stall_o, error_o};
    exp = {eEn, eEn ? eMaj : 16'h0, eEn ? eSrc : 2'h0,
           eEn ? mkPay(int'(eSrc), eMaj) : 16'h0, eStallO, eErr};
    chk(nm, act, exp);
  endtask

  initial begin
    //          en       m0  m1  m2  m3 st  eEn eMaj eSrc eStallO eErr
    tbl[0]  = '{4'b0010, 0,  5,  0,  0, 0,  0,  0,   0,  4'b0000, 0};
    tbl[1]  = '{4'b0000, 0,  0,  0,  0, 0,  1,  5,   1,  4'b0000, 0};
    tbl[2]  = '{4'b1101, 9,  0,  3,  7, 0,  0,  0,   0,  4'b0000, 0};
    tbl[3]  = '{4'b0000, 0,  0,  0,  0, 0,  1,  3,   2,  4'b0000, 0};
    tbl[4]  = '{4'b0000, 0,  0,  0,  0, 0,  1,  7,   3,  4'b0000, 0};
    tbl[5]  = '{4'b0000, 0,  0,  0,  0, 0,  1,  9,   0,  4'b0000, 0};
    tbl[6]  = '{4'b0000, 0,  0,  0,  0, 0,  0,  0,   0,  4'b0000, 0};
    tbl[7]  = '{4'b1010, 0,  4,  0,  4, 0,  0,  0,   0,  4'b0000, 0};
    tbl[8]  = '{4'b0000, 0,  0,  0,  0, 0,  1,  4,   1,  4'b0000, 0};
    tbl[9]  = '{4'b0000, 0,  0,  0,  0, 0,  1,  4,   3,  4'b0000, 0};
    tbl[10] = '{4'b0000, 0,  0,  0,  0, 0,  0,  0,   0,  4'b0000, 0};
    tbl[11] = '{4'b0001, 10, 0,  0,  0, 1,  0,  0,   0,  4'b0000, 0};
    tbl[12] = '{4'b0001, 11, 0,  0,  0, 1,  1,  10,  0,  4'b0000, 0};
    tbl[13] = '{4'b0001, 12, 0,  0,  0, 1,  1,  10,  0,  4'b0001, 0};
    tbl[14] = '{4'b0000, 0,  0,  0,  0, 1,  1,  10,  0,  4'b0001, 0};
    tbl[15] = '{4'b0001, 99, 0,  0,  0, 1,  1,  10,  0,  4'b0001, 1};
    tbl[16] = '{4'b0000, 0,  0,  0,  0, 0,  1,  11,  0,  4'b0000, 1};
    tbl[17] = '{4'b0000, 0,  0,  0,  0, 0,  1,  12,  0,  4'b0000, 1};
    tbl[18] = '{4'b0000, 0,  0,  0,  0, 0,  0,  0,   0,  4'b0000, 1};

    reset_i = 1'b0;
    drive(4'b0000, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clock_i);
    chk("reset_state", {enable_o, stall_o, error_o, majId_o, source_o, payload_o},
        {1'b0, 4'b0000, 1'b0, 16'h0, 2'h0, 16'h0});
    reset_i = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].en, tbl[i].m0, tbl[i].m1, tbl[i].m2, tbl[i].m3, tbl[i].stall);
      stepCheck($sformatf("vec%0d", i), tbl[i].eEn, tbl[i].eMaj, tbl[i].eSrc,
                tbl[i].eStallO, tbl[i].eErr);
    end

    // Mid-operation reset with entries queued and the output valid.
    drive(4'b0011, 20, 21, 0, 0, 1'b1);
    stepCheck("midrst_fill0", 1'b0, 0, 0, 4'b0000, 1'b1);
    drive(4'b0011, 30, 31, 0, 0, 1'b1);
    stepCheck("midrst_fill1", 1'b1, 20, 0, 4'b0010, 1'b1);
    drive(4'b0000, 0, 0, 0, 0, 1'b0);
    #2 reset_i = 1'b0;
    #1;
    chk("midrst_async", {enable_o, stall_o, error_o}, {1'b0, 4'b0000, 1'b0});
    @(negedge clock_i);
    reset_i = 1'b1;
    for (int i = 0; i < 4; i++)
      stepCheck($sformatf("midrst_drain%0d", i), 1'b0, 0, 0, 4'b0000, 1'b0);

    // Back-to-back stream on source 1.
    for (int i = 0; i < 64; i++) begin
      drive(4'b0010, 0, 16'(i), 0, 0, 1'b0);
      stepCheck($sformatf("stream%0d", i), i > 0, 16'(i - 1), 2'd1, 4'b0000, 1'b0);
    end
    drive(4'b0000, 0, 0, 0, 0, 1'b0);
    stepCheck("stream_last", 1'b1, 63, 1, 4'b0000, 1'b0);
    stepCheck("stream_idle", 1'b0, 0, 0, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_result_arbiter.md
Name: decode_result_arbiter

Overview:
- Merges result streams from numSources format-specific decoders into one in-order stream for the dispatch stage.
- Each source feeds a 2-entry FIFO. Every cycle the output register loads the oldest FIFO head, where oldest means the lowest major ID.
- Downstream backpressure (stall_i) propagates to the decoders as per-source stall_o.
- Sits between the format decoder bank and the dispatch/rename stage.

Parameters:
- numSources, 4: number of decoder sources (2..8).
- payloadWidth, 128: flattened decoder result (opcode, address, func unit, body, PID/TID, is64Bit) excluding major ID.
- instructionCounterWidth, 64: major ID width.
- fifoDepth, 2: entries per source FIFO. Fixed at 2; the parameter exists for documentation only.

Ports:
- clock_i, in, 1: clock, rising edge.
- reset_i, in, 1: asynchronous, active-low reset.
- enable_i, in, numSources: per-source result valid, one bit per decoder.
- payload_i, in, numSources*payloadWidth: source k occupies bits [k*payloadWidth +: payloadWidth].
- majId_i, in, numSources*instructionCounterWidth: source k major ID, packed the same way.
- stall_i, in, 1: downstream cannot accept.
- stall_o, out, numSources: source k FIFO full.
- enable_o, out, 1: output register valid.
- payload_o, out, payloadWidth: selected payload.
- majId_o, out, instructionCounterWidth: selected major ID.
- source_o, out, clog2(numSources): index of the winning source.
- error_o, out, 1: sticky overflow flag.

Behaviour:
- Reset: asserting reset_i low asynchronously clears all FIFO counts and pointers, enable_o, payload_o, majId_o, source_o and error_o to 0. stall_o reads 0. FIFO contents are don't-care. Reset asserted mid-operation discards all in-flight entries.
- Push: at a rising edge with enable_i[k]=1 and FIFO k count<2, the entry is written and count increments.
- Push to full: enable_i[k]=1 while count==2 is ignored, even if the same edge pops FIFO k, and error_o is set. error_o stays 1 until reset.
- stall_o[k] = (count_k==2). It is a combinational decode of the registered count.
- Output register:
  - It is free when enable_o==0, or when enable_o==1 and stall_i==0 (the consumer takes the entry at that edge).
  - When it is free and at least one FIFO is non-empty, it loads the head with the minimum majId, pops that FIFO and sets enable_o=1.
  - When it is free and all FIFOs are empty, enable_o becomes 0.
  - When enable_o==1 and stall_i==1, all outputs hold and nothing pops.
- Selection: unsigned compare across the full major ID width, with no wrap handling. Equal majId goes to the lowest source index. Only non-empty FIFOs take part.
- Push and pop on the same FIFO in one edge: count is unchanged. The popped entry is the old head; the pushed entry goes to the tail.
- A same-edge push is not visible to selection. Latency from enable_i to enable_o is 2 cycles minimum.
- Throughput: 1 result per cycle while stall_i==0.
- FIFO: 2 entries, 1-bit read/write pointers, 2-bit count. Pointers wrap modulo 2.

Optional Feature:
- DECODE_ARB_BYPASS_EN, when defined:
  - Condition: all FIFOs are empty, the output register is free, and at least one enable_i bit is set.
  - Action: the output register loads directly from the inputs at that edge, picking the minimum majId_i with ties to the lowest index. Latency is 1 cycle.
  - The other simultaneous inputs are pushed into their FIFOs.
- When undefined: all entries pass through the FIFOs, giving 2-cycle latency.

Test Plan:
- Reset and single entry: reset_i=0 then 1; push enable_i=4'b0010 with majId=5 → enable_o=1 two edges later (one edge with BYPASS), source_o=1, majId_o=5, stall_o=0, error_o=0.
- Ordering: one edge pushes src0 majId=9, src2 majId=3, src3 majId=7 → outputs in order 3,7,9 on consecutive cycles with stall_i=0. A src1 tie (both majId=4 on src1 and src3) → source_o=1 first.
- Backpressure: hold stall_i=1; push src0 three times with majIds 10,11,12 → the first loads the output register, the next two fill the FIFO, stall_o[0]=1. Release stall_i → majId_o sequence 10,11,12, stall_o[0] falls after the first pop.
- Overflow: with stall_o[0]=1, assert enable_i[0] majId=99 → entry dropped, error_o=1 held until reset. 99 never appears on majId_o.
- Mid-operation reset: with 2 entries queued and enable_o=1, pull reset_i low between clock edges → enable_o, stall_o, error_o read 0 immediately. After release, no stale entries emerge.
- Streaming: src1 pushes majId 0..63 every cycle with stall_i=0 → enable_o continuously 1 after the latency, majId_o increments by 1 per cycle, stall_o never asserts.
